// File: rtl/node_turn_pkg.sv
// Shared types for the node turn controller: FSM states, per-node actions, timer width.
// Timers are saturating counters of TMR_W bits.
package node_turn_pkg;

  localparam int TMR_W = 26;

  typedef enum logic [2:0] {
    CRUISE,
    SETTLE,
    DECIDE,
    BLIND,
    SEEK,
    DONE,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    ACT_STRAIGHT = 2'd0,
    ACT_LEFT     = 2'd1,
    ACT_RIGHT    = 2'd2,
    ACT_STOP     = 2'd3
  } act_t;

  function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] t);
    return (t == {TMR_W{1'b1}}) ? t : t + 1'b1;
  endfunction

endpackage

// File: rtl/node_turn_fsm_if.sv
// Node detector / sensor inputs and motor, progress and status outputs of the turn controller.
// Optional fault status line exists only when TURN_TIMEOUT_EN is defined.
interface node_turn_fsm_if #(
  parameter int NCH = 3
);
  logic              node;
  logic [12*NCH-1:0] sens;
  logic              node_done;
  logic [7:0]        lm;
  logic [7:0]        lmn;
  logic [7:0]        rm;
  logic [7:0]        rmn;
  logic [4:0]        node_count;
  logic [2:0]        lap;
  logic              halted;
`ifdef TURN_TIMEOUT_EN
  logic              fault;

  modport master (output node, sens,
                  input  node_done, lm, lmn, rm, rmn, node_count, lap, halted, fault);
  modport slave  (input  node, sens,
                  output node_done, lm, lmn, rm, rmn, node_count, lap, halted, fault);
`else
  modport master (output node, sens,
                  input  node_done, lm, lmn, rm, rmn, node_count, lap, halted);
  modport slave  (input  node, sens,
                  output node_done, lm, lmn, rm, rmn, node_count, lap, halted);
`endif
endinterface

// File: rtl/node_turn_fsm_line_detect.sv
// Line present when any of NCH 12-bit channels is strictly above TH; one cycle latency.
// No backpressure: samples every cycle.
module line_detect #(
  parameter int         NCH = 3,
  parameter logic [11:0] TH = 12'h500
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic [12*NCH-1:0] sens,
  output logic              line
);

  logic hit;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (sens[12*i +: 12] > TH) hit = 1'b1;
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) line <= 1'b0;
    else     line <= hit;
  end

endmodule

// File: rtl/node_turn_fsm.sv
// Node turn controller: cruise between nodes, settle/count at a node, then spin and seek per PLAN.
// All outputs registered; TURN_TIMEOUT_EN adds a SEEK timeout that halts with fault.
module node_turn_fsm
  import node_turn_pkg::*;
#(
  parameter int                 NCH        = 3,
  parameter int                 NODES      = 8,
  parameter int                 LAPS       = 2,
  parameter logic [2*NODES-1:0] PLAN       = 16'h4924,
  parameter int                 SETTLE_CYC = 21000000,
  parameter int                 BLIND_CYC  = 25000000,
  parameter logic [11:0]        LINE_TH    = 12'h500,
  parameter int                 CRUISE_L   = 77,
  parameter int                 CRUISE_R   = 80
`ifdef TURN_TIMEOUT_EN
  , parameter int               SEEK_MAX_CYC = 50000000
`endif
) (
  input logic             clk_50,
  input logic             rst,
  node_turn_fsm_if.slave  bus
);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] BLIND_LAST  = TMR_W'(BLIND_CYC - 1);
  localparam logic [7:0]       DUTY_L      = 8'(CRUISE_L);
  localparam logic [7:0]       DUTY_R      = 8'(CRUISE_R);
`ifdef TURN_TIMEOUT_EN
  localparam logic [TMR_W-1:0] SEEK_LAST   = TMR_W'(SEEK_MAX_CYC - 1);
`endif

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [4:0]       node_count;
  logic [2:0]       lap;
  logic             node_done;
  logic             halted;
  logic [7:0]       lm, lmn, rm, rmn;
  logic             line_q;
  logic [2*NODES-1:0] plan_sh;
  act_t             act;
  logic             last_node;
`ifdef TURN_TIMEOUT_EN
  logic             fault;
  assign bus.fault = fault;
`endif

  line_detect #(.NCH(NCH), .TH(LINE_TH)) u_line (
    .clk_50 (clk_50),
    .rst    (rst),
    .sens   (bus.sens),
    .line   (line_q)
  );

  // Node 1 lives in the PLAN LSBs, so the node_count-1 pair is the current action.
  always_comb begin
    plan_sh   = PLAN >> {node_count - 5'd1, 1'b0};
    act       = act_t'(plan_sh[1:0]);
    last_node = (node_count == 5'(NODES)) && (lap == 3'(LAPS));
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state      <= CRUISE;
      tmr        <= '0;
      node_count <= '0;
      lap        <= 3'd1;
      node_done  <= 1'b0;
      halted     <= 1'b0;
      lm         <= DUTY_L;
      rm         <= DUTY_R;
      lmn        <= 8'd0;
      rmn        <= 8'd0;
`ifdef TURN_TIMEOUT_EN
      fault      <= 1'b0;
`endif
    end else begin
      case (state)
        CRUISE: begin
          if (bus.node) begin
            state <= SETTLE;
            tmr   <= '0;
          end
        end
        SETTLE: begin
          if (!bus.node) begin
            state <= CRUISE;
          end else if (tmr >= SETTLE_LAST) begin
            if (node_count == 5'(NODES)) begin
              node_count <= 5'd1;
              lap        <= (lap == 3'd7) ? lap : lap + 3'd1;
            end else begin
              node_count <= node_count + 5'd1;
            end
            lm    <= 8'd0;
            rm    <= 8'd0;
            lmn   <= 8'd0;
            rmn   <= 8'd0;
            state <= DECIDE;
          end else begin
            tmr <= tmr_inc(tmr);
          end
        end
        DECIDE: begin
          tmr <= '0;
          if (last_node || act == ACT_STOP) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            case (act)
              ACT_LEFT: begin
                lmn   <= DUTY_L;
                rm    <= DUTY_R;
                state <= BLIND;
              end
              ACT_RIGHT: begin
                lm    <= DUTY_L;
                rmn   <= DUTY_R;
                state <= BLIND;
              end
              default: begin
                node_done <= 1'b1;
                state     <= DONE;
              end
            endcase
          end
        end
        BLIND: begin
          if (tmr >= BLIND_LAST) begin
            tmr   <= '0;
            state <= SEEK;
          end else begin
            tmr <= tmr_inc(tmr);
          end
        end
        SEEK: begin
          if (line_q) begin
            lm        <= 8'd0;
            rm        <= 8'd0;
            lmn       <= 8'd0;
            rmn       <= 8'd0;
            node_done <= 1'b1;
            state     <= DONE;
          end
`ifdef TURN_TIMEOUT_EN
          else if (tmr >= SEEK_LAST) begin
            lm     <= 8'd0;
            rm     <= 8'd0;
            lmn    <= 8'd0;
            rmn    <= 8'd0;
            halted <= 1'b1;
            fault  <= 1'b1;
            state  <= HALT;
          end else begin
            tmr <= tmr_inc(tmr);
          end
`endif
        end
        DONE: begin
          if (!bus.node) begin
            node_done <= 1'b0;
            lm        <= DUTY_L;
            rm        <= DUTY_R;
            state     <= CRUISE;
          end
        end
        HALT: begin
          lm     <= 8'd0;
          rm     <= 8'd0;
          lmn    <= 8'd0;
          rmn    <= 8'd0;
          halted <= 1'b1;
        end
        default: state <= CRUISE;
      endcase
    end
  end

  assign bus.node_done  = node_done;
  assign bus.halted     = halted;
  assign bus.node_count = node_count;
  assign bus.lap        = lap;
  assign bus.lm         = lm;
  assign bus.lmn        = lmn;
  assign bus.rm         = rm;
  assign bus.rmn        = rmn;

endmodule

// File: tb/tb_node_turn_fsm.sv
// Directed bench for node_turn_fsm with NODES=3, LAPS=2, plan left/right/straight, short timers.
// With TURN_TIMEOUT_EN defined, the SEEK timeout path is also exercised.
module tb_node_turn_fsm;

  localparam int SETTLE = 10;
  localparam int BLINDC = 5;

  logic clk_50 = 1'b0;
  logic rst    = 1'b1;
  int   n_vec  = 0;
  int   n_err  = 0;

  always #5 clk_50 = ~clk_50;

  node_turn_fsm_if #(.NCH(3)) bus ();

  node_turn_fsm #(
    .NCH        (3),
    .NODES      (3),
    .LAPS       (2),
    .PLAN       (6'b00_10_01),
    .SETTLE_CYC (SETTLE),
    .BLIND_CYC  (BLINDC),
    .LINE_TH    (12'h500),
    .CRUISE_L   (77),
    .CRUISE_R   (80)
`ifdef TURN_TIMEOUT_EN
    , .SEEK_MAX_CYC (30)
`endif
  ) dut (
    .clk_50 (clk_50),
    .rst    (rst),
    .bus    (bus)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  function automatic logic [35:0] mk_sens(input logic [11:0] c0, input logic [11:0] c1,
                                          input logic [11:0] c2);
    return {c2, c1, c0};
  endfunction

  task automatic wait_count(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (bus.node_count == 5'(target)) ok = 1'b1;
    end
  endtask

  // Drive one node with line already visible and hold it until the block finishes or halts.
  task automatic pass_node(output bit ok);
    bus.node = 1'b1;
    bus.sens = mk_sens(12'h000, 12'hfff, 12'h000);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (bus.node_done || bus.halted) ok = 1'b1;
    end
    bus.node = 1'b0;
    bus.sens = '0;
    tick();
    tick();
  endtask

  task automatic check_motors(input string tag, input int l, input int ln, input int r,
                              input int rn);
    check_val({tag, "_lm"},  int'(bus.lm),  l);
    check_val({tag, "_lmn"}, int'(bus.lmn), ln);
    check_val({tag, "_rm"},  int'(bus.rm),  r);
    check_val({tag, "_rmn"}, int'(bus.rmn), rn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt;
    int bad;

    bus.node = 1'b0;
    bus.sens = '0;
    rst = 1'b1;
    tick();
    tick();
    check_motors("reset", 77, 0, 80, 0);
    check_val("reset_count", int'(bus.node_count), 0);
    check_val("reset_lap", int'(bus.lap), 1);
    check_val("reset_done", int'(bus.node_done), 0);
    check_val("reset_halted", int'(bus.halted), 0);
    rst = 1'b0;

    // A 9-cycle node pulse is too short to count.
    bus.node = 1'b1;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.node_count != 0 || bus.lm != 8'd77 || bus.rm != 8'd80 || bus.node_done) bad++;
    end
    bus.node = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.node_count != 0 || bus.lm != 8'd77 || bus.rm != 8'd80 || bus.node_done) bad++;
    end
    check_val("short_pulse_bad_cycles", bad, 0);

    // Node 1: left spin, node dropped mid-turn, line held at threshold then just above.
    bus.node = 1'b1;
    wait_count(1, ok);
    check_val("n1_reached", int'(ok), 1);
    check_motors("n1_decide", 0, 0, 0, 0);
    tick();
    check_motors("n1_spin", 0, 77, 80, 0);
    bus.node = 1'b0;
    for (int i = 0; i < BLINDC + 20; i++) tick();
    check_motors("n1_seek", 0, 77, 80, 0);
    check_val("n1_seek_done", int'(bus.node_done), 0);
    bus.sens = mk_sens(12'h000, 12'h000, 12'h500);
    for (int i = 0; i < 3; i++) tick();
    check_val("n1_at_th_lmn", int'(bus.lmn), 77);
    bus.sens = mk_sens(12'h501, 12'h000, 12'h000);
    tick();
    check_val("n1_line1_lmn", int'(bus.lmn), 77);
    check_val("n1_line1_done", int'(bus.node_done), 0);
    tick();
    check_motors("n1_line2", 0, 0, 0, 0);
    check_val("n1_line2_done", int'(bus.node_done), 1);
    tick();
    check_motors("n1_resume", 77, 0, 80, 0);
    check_val("n1_resume_done", int'(bus.node_done), 0);
    bus.sens = '0;

    // Node 2: right spin with line visible throughout; spin lasts BLIND plus one SEEK cycle.
    bus.sens = mk_sens(12'h000, 12'h000, 12'h800);
    bus.node = 1'b1;
    wait_count(2, ok);
    check_val("n2_reached", int'(ok), 1);
    tick();
    check_motors("n2_spin", 77, 0, 0, 80);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.rmn == 8'd80) cnt++;
      else break;
    end
    check_val("n2_spin_cycles", cnt, BLINDC + 1);
    check_val("n2_done", int'(bus.node_done), 1);
    tick();
    tick();
    check_val("n2_done_held", int'(bus.node_done), 1);
    check_motors("n2_done_held", 0, 0, 0, 0);
    bus.node = 1'b0;
    bus.sens = '0;
    tick();
    check_motors("n2_resume", 77, 0, 80, 0);

    // Node 3: straight, no spin.
    bus.node = 1'b1;
    wait_count(3, ok);
    check_val("n3_reached", int'(ok), 1);
    tick();
    check_val("n3_done", int'(bus.node_done), 1);
    check_motors("n3_done", 0, 0, 0, 0);
    check_val("n3_lap", int'(bus.lap), 1);
    bus.node = 1'b0;
    tick();
    check_val("n3_resume_lm", int'(bus.lm), 77);

    // Lap 2: count wraps to 1, then the final node halts the run.
    pass_node(ok);
    check_val("l2n1_ok", int'(ok), 1);
    check_val("l2n1_count", int'(bus.node_count), 1);
    check_val("l2n1_lap", int'(bus.lap), 2);
    pass_node(ok);
    check_val("l2n2_ok", int'(ok), 1);
    check_val("l2n2_count", int'(bus.node_count), 2);
    check_val("l2n2_halted", int'(bus.halted), 0);
    pass_node(ok);
    check_val("l2n3_ok", int'(ok), 1);
    check_val("l2n3_count", int'(bus.node_count), 3);
    check_val("l2n3_halted", int'(bus.halted), 1);
    check_val("l2n3_done", int'(bus.node_done), 0);
    check_motors("l2n3_halt", 0, 0, 0, 0);
    for (int p = 0; p < 2; p++) begin
      bus.node = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      bus.node = 1'b0;
      for (int i = 0; i < 3; i++) tick();
    end
    check_val("halt_stays", int'(bus.halted), 1);
    check_val("halt_count", int'(bus.node_count), 3);
    check_val("halt_lap", int'(bus.lap), 2);
    check_motors("halt_stays", 0, 0, 0, 0);

    // Reset during SEEK restores cruise and counters on the next edge.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst2_halted", int'(bus.halted), 0);
    bus.node = 1'b1;
    wait_count(1, ok);
    check_val("rs_reached", int'(ok), 1);
    for (int i = 0; i < BLINDC + 4; i++) tick();
    check_motors("rs_seek", 0, 77, 80, 0);
    rst = 1'b1;
    tick();
    check_motors("rs_reset", 77, 0, 80, 0);
    check_val("rs_count", int'(bus.node_count), 0);
    check_val("rs_lap", int'(bus.lap), 1);
    check_val("rs_done", int'(bus.node_done), 0);
    rst = 1'b0;
    bus.node = 1'b0;
    tick();

`ifdef TURN_TIMEOUT_EN
    // No line during SEEK: halt with fault after 30 SEEK cycles.
    check_val("to_fault_init", int'(bus.fault), 0);
    bus.node = 1'b1;
    wait_count(1, ok);
    check_val("to_reached", int'(ok), 1);
    bus.node = 1'b0;
    for (int i = 0; i < 1 + BLINDC + 29; i++) tick();
    check_val("to_before_fault", int'(bus.fault), 0);
    check_val("to_before_halted", int'(bus.halted), 0);
    tick();
    check_val("to_fault", int'(bus.fault), 1);
    check_val("to_halted", int'(bus.halted), 1);
    check_motors("to_halt", 0, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/node_turn_fsm.md
Name: node_turn_fsm

Overview:
Parametrised successor to the single-plan node turn controller in the line-follow drive path. It sits between the node detector and the motor PWM drivers. While the bot is between nodes it outputs forward-cruise duties. At each node it counts the node, looks up a per-node action (straight, left or right), performs a timed blind spin followed by a line-seek, then hands control back. It supports configurable sensor channel count, node count, lap limit and threshold.

Parameters:
NCH, 3, number of 12-bit line-sensor channels examined at a node
NODES, 8, nodes per lap; node_count runs 1..NODES
LAPS, 2, laps to run; after node NODES of lap LAPS the block stops the bot
PLAN, 16'h4924 (2 bits per node, node 1 in LSBs), action per node: 0=straight, 1=left, 2=right, 3=stop
SETTLE_CYC, 21000000, cycles node must be held before the action is taken
BLIND_CYC, 25000000, minimum spin cycles before the line-seek starts
LINE_TH, 12'h500, a sensor reading strictly above this value counts as line
CRUISE_L, 77, left forward duty
CRUISE_R, 80, right forward duty

Ports:
clk_50  in  1  system clock (50 MHz)
rst  in  1  synchronous active-high reset
node  in  1  node-present flag from the node detector
sens  in  12*NCH  packed sensor readings; channel i is at [12*i+11:12*i]
node_done  out  1  action at the current node is finished; the line follower may resume
lm, lmn, rm, rmn  out  8 each  motor PWM duties (forward/reverse, left/right)
node_count  out  5  current node index, 0 before the first node
lap  out  3  current lap, starting at 1
halted  out  1  run complete or a stop action was taken

Behaviour:
- Reset values: state=CRUISE, node_count=0, lap=1, node_done=0, halted=0, lm=CRUISE_L, rm=CRUISE_R, lmn=rmn=0. All timers are cleared.
- line = OR over channels of (sens_i > LINE_TH). line is registered, so the FSM sees it 1 cycle late.
- States:
  - CRUISE: outputs forward duties. When node=1, go to SETTLE and clear the timer.
  - SETTLE: the timer counts while node=1. If node drops before the count finishes, return to CRUISE with no count change. When the timer reaches SETTLE_CYC:
    - If node_count==NODES, then node_count=1 and lap=lap+1. Otherwise node_count=node_count+1.
    - All motor outputs are set to 0.
    - Go to DECIDE.
  - DECIDE (1 cycle), using the action for the new node_count:
    - If this is node NODES on lap LAPS, or the action is 3: go to HALT.
    - Straight: go to DONE.
    - Left: lmn=CRUISE_L, rm=CRUISE_R, others 0. Go to BLIND.
    - Right: lm=CRUISE_L, rmn=CRUISE_R, others 0. Go to BLIND.
  - BLIND: counts to BLIND_CYC, ignoring line, then goes to SEEK.
  - SEEK: on the first registered line=1, set all motor outputs to 0 and go to DONE.
  - DONE: node_done=1 and motors are 0. When node=0, set node_done=0, restore cruise duties and go to CRUISE next cycle.
  - HALT: all motors 0 and halted=1. Only rst leaves this state.
- node falling during DECIDE, BLIND or SEEK is ignored; the turn completes first.
- Timers are 26 bits and saturate; they never wrap.
- Reset mid-turn restores the reset values on the next edge. Motors leave spin immediately.
- The lap counter saturates at 7.

Optional Feature:
TURN_TIMEOUT_EN
- Defined: a SEEK_MAX_CYC parameter (default 50000000) is added. If SEEK runs SEEK_MAX_CYC cycles without seeing line, the FSM goes to HALT and a fault output (1 bit, reset 0) is asserted.
- Undefined: SEEK waits indefinitely and there is no fault port.

Decomposition:
- Package node_turn_pkg holds:
  - the state enum (CRUISE, SETTLE, DECIDE, BLIND, SEEK, DONE, HALT);
  - the action enum (ACT_STRAIGHT, ACT_LEFT, ACT_RIGHT, ACT_STOP);
  - the timer width constant.
- One sub-module, line_detect: the parametrised NCH-channel threshold OR with an output register.

Test Plan:
- Settle: small params (SETTLE_CYC=10, BLIND_CYC=5). Pulse node for 9 cycles, then 0 → node_count stays 0, duties stay 77/80, node_done never set.
- Left turn: PLAN node1=left. Hold node, line low until 20 cycles after BLIND, then raise line → lmn=77 and rm=80 during the spin; all motors 0 and node_done=1 exactly 2 cycles after line rises.
- Early line: line high throughout BLIND → no exit before BLIND_CYC elapses, then SEEK exits on the 2nd cycle.
- Laps and halt: NODES=3, LAPS=2, all straight → node_count sequence 1,2,3,1,2,3 with lap incrementing to 2. At node 3 of lap 2, halted=1, motors 0, and it stays there through further node pulses.
- Reset mid-SEEK: assert rst during SEEK → next edge gives lm=77, rm=80, lmn=rmn=0, node_count=0, lap=1.
- TURN_TIMEOUT_EN, SEEK_MAX_CYC=30: line never rises → fault=1 and halted=1 after 30 SEEK cycles.
